sfp_acc_ctrl: RTL and testbench



---
 rtl/sfp_acc_ctrl.sv | 111 +++++++++++
 tb/tb_sfp_acc_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sfp_acc_ctrl.sv
// Sequencer for one SFP row: per output pixel, clear, issue len_kij psum reads, drain, write the ReLU result.
// Per-pixel latency len_kij+3 cycles with no stall; stall freezes read issue and write in place.
module sfp_acc_ctrl #(
  parameter int len_kij  = 9,
  parameter int len_onij = 16,
  parameter int addr_bw  = 11
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stall,
  output logic               busy,
  output logic               done,
  output logic               pmem_rd,
  output logic [addr_bw-1:0] pmem_addr,
  output logic               sfp_acc,
  output logic               sfp_clr,
  output logic               omem_wr,
  output logic [addr_bw-1:0] omem_addr
);

  localparam int KW = (len_kij > 1) ? $clog2(len_kij) : 1;
  localparam int OW = (len_onij > 1) ? $clog2(len_onij) : 1;
  localparam logic [KW-1:0]      KIJ_LAST  = KW'(len_kij - 1);
  localparam logic [OW-1:0]      O_LAST    = OW'(len_onij - 1);
  localparam logic [addr_bw-1:0] BASE_STEP = addr_bw'(len_onij);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_READ, S_DRAIN, S_WRITE, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [KW-1:0]      kij_q, kij_d;
  logic [OW-1:0]      o_q, o_d;
  logic [addr_bw-1:0] base_q, base_d;
  logic               acc_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      kij_q   <= '0;
      o_q     <= '0;
      base_q  <= '0;
      acc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      kij_q   <= kij_d;
      o_q     <= o_d;
      base_q  <= base_d;
      acc_q   <= pmem_rd;
    end
  end

  // base_q tracks kij*len_onij so the read address needs only one adder.
  always_comb begin
    state_d   = state_q;
    kij_d     = kij_q;
    o_d       = o_q;
    base_d    = base_q;
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
    sfp_clr   = (state_q == S_CLEAR);
    pmem_rd   = 1'b0;
    pmem_addr = '0;
    omem_wr   = 1'b0;
    omem_addr = '0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CLEAR;
          kij_d   = '0;
          o_d     = '0;
          base_d  = '0;
        end
      end
      S_CLEAR: state_d = S_READ;
      S_READ: begin
        if (!stall) begin
          pmem_rd   = 1'b1;
          pmem_addr = base_q + addr_bw'(o_q);
          if (kij_q == KIJ_LAST) begin
            state_d = S_DRAIN;
          end else begin
            kij_d  = kij_q + KW'(1);
            base_d = base_q + BASE_STEP;
          end
        end
      end
      S_DRAIN: state_d = S_WRITE;
      S_WRITE: begin
        if (!stall) begin
          omem_wr   = 1'b1;
          omem_addr = addr_bw'(o_q);
          if (o_q == O_LAST) begin
            state_d = S_DONE;
          end else begin
            o_d     = o_q + OW'(1);
            kij_d   = '0;
            base_d  = '0;
            state_d = S_CLEAR;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign sfp_acc = acc_q;

endmodule

// File: tb/tb_sfp_acc_ctrl.sv
// Bench for sfp_acc_ctrl: table of per-cycle output vectors for directed runs plus a
// transaction-level reference (expected read/write address lists) checked on random-stall runs.
module tb_sfp_acc_ctrl;
  localparam int LK = 9, LO = 16, AW = 11, BUDGET = 3000;

  typedef struct packed {
    logic busy, done, clr, rd;
    logic [AW-1:0] addr;
    logic acc, wr;
    logic [AW-1:0] waddr;
  } out_t;

  typedef struct {
    int   mode;
    int   cyc;
    bit   use_b;
    out_t exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset, start, stall;
  logic busy, done, pmem_rd, sfp_acc, sfp_clr, omem_wr;
  logic [AW-1:0] pmem_addr, omem_addr;
  logic b_busy, b_done, b_pmem_rd, b_sfp_acc, b_sfp_clr, b_omem_wr;
  logic [AW-1:0] b_pmem_addr, b_omem_addr;

  always #5 clk = ~clk;

  sfp_acc_ctrl #(.len_kij(LK), .len_onij(LO), .addr_bw(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall),
    .busy(busy), .done(done), .pmem_rd(pmem_rd), .pmem_addr(pmem_addr),
    .sfp_acc(sfp_acc), .sfp_clr(sfp_clr), .omem_wr(omem_wr), .omem_addr(omem_addr)
  );

  sfp_acc_ctrl #(.len_kij(1), .len_onij(1), .addr_bw(AW)) dut_b (
    .clk(clk), .reset(reset), .start(start), .stall(stall),
    .busy(b_busy), .done(b_done), .pmem_rd(b_pmem_rd), .pmem_addr(b_pmem_addr),
    .sfp_acc(b_sfp_acc), .sfp_clr(b_sfp_clr), .omem_wr(b_omem_wr), .omem_addr(b_omem_addr)
  );

  int   checks = 0, failures = 0;
  int   cyc, acc_cnt, clr_cnt, done_cnt;
  bit   mon_en, prev_rd;
  int   exp_rd[$], exp_wr[$];
  out_t log_a[0:BUDGET];
  out_t log_b[0:BUDGET];
  vec_t tbl[$];

  function automatic out_t pk(input logic bz, dn, cl, rd, input logic [AW-1:0] ad,
                              input logic ac, wr, input logic [AW-1:0] wa);
    return out_t'({bz, dn, cl, rd, ad, ac, wr, wa});
  endfunction

  function automatic out_t cur_a();
    return pk(busy, done, sfp_clr, pmem_rd, pmem_addr, sfp_acc, omem_wr, omem_addr);
  endfunction

  function automatic out_t cur_b();
    return pk(b_busy, b_done, b_sfp_clr, b_pmem_rd, b_pmem_addr, b_sfp_acc, b_omem_wr, b_omem_addr);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Mode 0: no stall, 1: random stall, 2: stall at o=2/kij=4 read, 3: stall entering first write.
  function automatic bit stall_for(input int mode, input int c);
    case (mode)
      1:       return ($urandom_range(0, 3) == 0);
      2:       return (c >= 30 && c <= 32);
      3:       return (c >= 12 && c <= 13);
      default: return 1'b0;
    endcase
  endfunction

  function automatic int exp_done_cyc(input int mode);
    case (mode)
      0:       return LO * (LK + 3) + 1;
      2:       return LO * (LK + 3) + 1 + 3;
      3:       return LO * (LK + 3) + 1 + 2;
      default: return -1;
    endcase
  endfunction

  task automatic monitor();
    check("acc_follows_rd", sfp_acc, prev_rd);
    if (stall) check("stall_gates_io", {pmem_rd, omem_wr}, 0);
    if (!pmem_rd) check("rd_addr_zero", pmem_addr, 0);
    else if (exp_rd.size() == 0) check("extra_read", 1, 0);
    else check("rd_addr", pmem_addr, exp_rd.pop_front());
    if (!omem_wr) check("wr_addr_zero", omem_addr, 0);
    else begin
      check("acc_per_pixel", acc_cnt, LK);
      acc_cnt = 0;
      if (exp_wr.size() == 0) check("extra_write", 1, 0);
      else check("wr_addr", omem_addr, exp_wr.pop_front());
    end
    if (sfp_acc) acc_cnt++;
    if (sfp_clr) begin
      clr_cnt++;
      check("clr_acc_clean", acc_cnt, 0);
    end
    if (done) done_cnt++;
    prev_rd = pmem_rd;
  endtask

  task automatic step(input bit st, input bit sv);
    @(posedge clk);
    #1;
    start = st;
    stall = sv;
    @(negedge clk);
    cyc++;
    if (cyc <= BUDGET) begin
      log_a[cyc] = cur_a();
      log_b[cyc] = cur_b();
    end
    if (mon_en) monitor();
  endtask

  task automatic do_run(input int mode, input bit hold, output int done_cyc);
    bit stop;
    exp_rd.delete();
    exp_wr.delete();
    for (int o = 0; o < LO; o++) begin
      for (int k = 0; k < LK; k++) exp_rd.push_back(k * LO + o);
      exp_wr.push_back(o);
    end
    acc_cnt = 0; clr_cnt = 0; done_cnt = 0; prev_rd = 1'b0;
    done_cyc = -1; cyc = 0; mon_en = 1'b1; stop = 1'b0;
    start = 1'b1;
    stall = 1'b0;
    while (!stop) begin
      step(hold, stall_for(mode, cyc + 1));
      if (done && done_cyc < 0) done_cyc = cyc;
      if (done_cyc >= 0 && cyc == done_cyc + 1) mon_en = 1'b0;
      if (done_cyc >= 0 && cyc == done_cyc + (hold ? 2 : 1)) stop = 1'b1;
      if (cyc >= BUDGET) begin
        check("run_timeout", 0, 1);
        stop = 1'b1;
      end
    end
    mon_en = 1'b0;
    stall  = 1'b0;
    if (!hold) start = 1'b0;
    check("reads_left", exp_rd.size(), 0);
    check("writes_left", exp_wr.size(), 0);
    check("done_pulses", done_cnt, 1);
    check("clr_count", clr_cnt, LO);
    if (exp_done_cyc(mode) >= 0) check($sformatf("done_cycle_m%0d", mode), done_cyc, exp_done_cyc(mode));
  endtask

  task automatic apply_table(input int mode);
    foreach (tbl[i]) begin
      if (tbl[i].mode == mode) begin
        check($sformatf("vec_m%0d_c%0d%s", mode, tbl[i].cyc, tbl[i].use_b ? "_small" : ""),
              tbl[i].use_b ? log_b[tbl[i].cyc] : log_a[tbl[i].cyc], tbl[i].exp);
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int dc;
    // {mode, cycle, small instance?, {busy,done,clr,rd,addr,acc,wr,waddr}}
    tbl.push_back(vec_t'{0,   1, 1'b0, pk(1,0,1,0,  0,0,0, 0)});
    tbl.push_back(vec_t'{0,   2, 1'b0, pk(1,0,0,1,  0,0,0, 0)});
    tbl.push_back(vec_t'{0,   3, 1'b0, pk(1,0,0,1, 16,1,0, 0)});
    tbl.push_back(vec_t'{0,  10, 1'b0, pk(1,0,0,1,128,1,0, 0)});
    tbl.push_back(vec_t'{0,  11, 1'b0, pk(1,0,0,0,  0,1,0, 0)});
    tbl.push_back(vec_t'{0,  12, 1'b0, pk(1,0,0,0,  0,0,1, 0)});
    tbl.push_back(vec_t'{0,  13, 1'b0, pk(1,0,1,0,  0,0,0, 0)});
    tbl.push_back(vec_t'{0,  15, 1'b0, pk(1,0,0,1, 17,1,0, 0)});
    tbl.push_back(vec_t'{0, 192, 1'b0, pk(1,0,0,0,  0,0,1,15)});
    tbl.push_back(vec_t'{0, 193, 1'b0, pk(1,1,0,0,  0,0,0, 0)});
    tbl.push_back(vec_t'{0, 194, 1'b0, pk(0,0,0,0,  0,0,0, 0)});
    tbl.push_back(vec_t'{0,   1, 1'b1, pk(1,0,1,0,  0,0,0, 0)});
    tbl.push_back(vec_t'{0,   2, 1'b1, pk(1,0,0,1,  0,0,0, 0)});
    tbl.push_back(vec_t'{0,   3, 1'b1, pk(1,0,0,0,  0,1,0, 0)});
    tbl.push_back(vec_t'{0,   4, 1'b1, pk(1,0,0,0,  0,0,1, 0)});
    tbl.push_back(vec_t'{0,   5, 1'b1, pk(1,1,0,0,  0,0,0, 0)});
    tbl.push_back(vec_t'{0,   6, 1'b1, pk(0,0,0,0,  0,0,0, 0)});
    tbl.push_back(vec_t'{2,  29, 1'b0, pk(1,0,0,1, 50,1,0, 0)});
    tbl.push_back(vec_t'{2,  30, 1'b0, pk(1,0,0,0,  0,1,0, 0)});
    tbl.push_back(vec_t'{2,  31, 1'b0, pk(1,0,0,0,  0,0,0, 0)});
    tbl.push_back(vec_t'{2,  32, 1'b0, pk(1,0,0,0,  0,0,0, 0)});
    tbl.push_back(vec_t'{2,  33, 1'b0, pk(1,0,0,1, 66,0,0, 0)});
    tbl.push_back(vec_t'{2,  34, 1'b0, pk(1,0,0,1, 82,1,0, 0)});
    tbl.push_back(vec_t'{2, 196, 1'b0, pk(1,1,0,0,  0,0,0, 0)});
    tbl.push_back(vec_t'{3,  11, 1'b0, pk(1,0,0,0,  0,1,0, 0)});
    tbl.push_back(vec_t'{3,  12, 1'b0, pk(1,0,0,0,  0,0,0, 0)});
    tbl.push_back(vec_t'{3,  13, 1'b0, pk(1,0,0,0,  0,0,0, 0)});
    tbl.push_back(vec_t'{3,  14, 1'b0, pk(1,0,0,0,  0,0,1, 0)});
    tbl.push_back(vec_t'{3,  15, 1'b0, pk(1,0,1,0,  0,0,0, 0)});
    tbl.push_back(vec_t'{3,  16, 1'b0, pk(1,0,0,1,  1,0,0, 0)});
    tbl.push_back(vec_t'{3, 195, 1'b0, pk(1,1,0,0,  0,0,0, 0)});

    mon_en = 1'b0;
    reset = 1'b1;
    start = 1'b0;
    stall = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_state", cur_a(), 0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_after_reset", cur_a(), 0);

    foreach (tbl[i]) begin end
    do_run(0, 1'b0, dc); apply_table(0);
    do_run(2, 1'b0, dc); apply_table(2);
    do_run(3, 1'b0, dc); apply_table(3);
    repeat (3) do_run(1, 1'b0, dc);

    // start held high for the whole run: one run only, next one begins from IDLE after DONE
    do_run(0, 1'b1, dc);
    check("hold_single_run", dc, 193);
    check("hold_idle_gap", log_a[dc + 1].busy, 0);
    check("hold_restart_clr", log_a[dc + 2].clr, 1);
    start = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // asynchronous reset in the middle of a run
    cyc = 0;
    start = 1'b1;
    repeat (49) step(1'b0, 1'b0);
    @(posedge clk);
    #2;
    check("busy_before_reset", busy, 1);
    #1 reset = 1'b1;
    #1 check("reset_outputs_now", cur_a(), 0);
    repeat (2) @(negedge clk);
    check("reset_held_quiet", cur_a(), 0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_after_abort", cur_a(), 0);
    do_run(0, 1'b0, dc); apply_table(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
